// File: rtl/clk_freq_scan_ctrl_if.sv
// rtl/clk_freq_scan_ctrl_if.sv - control, status and capture signals of the clock-frequency scanner
interface clk_freq_scan_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic              iENABLE;
  logic [23:0]       iCNT_MIN;
  logic [23:0]       iCNT_MAX;
  logic [23:0]       iCLK_CNT;
  logic              iERR_CLR;
  logic [SEL_W-1:0]  oSEL;
  logic              oCAPT_VLD;
  logic [SEL_W-1:0]  oCAPT_CH;
  logic [23:0]       oCAPT_CNT;
  logic [NUM_CH-1:0] oFREQ_OK;
  logic [NUM_CH-1:0] oFREQ_ERR;
  logic              oSCAN_DONE;

  modport master (
    output iENABLE, iCNT_MIN, iCNT_MAX, iCLK_CNT, iERR_CLR,
    input  oSEL, oCAPT_VLD, oCAPT_CH, oCAPT_CNT, oFREQ_OK, oFREQ_ERR, oSCAN_DONE
  );

  modport slave (
    input  iENABLE, iCNT_MIN, iCNT_MAX, iCLK_CNT, iERR_CLR,
    output oSEL, oCAPT_VLD, oCAPT_CH, oCAPT_CNT, oFREQ_OK, oFREQ_ERR, oSCAN_DONE
  );
endinterface

// File: rtl/clk_freq_scan_ctrl.sv
// rtl/clk_freq_scan_ctrl.sv - time-multiplexed clock-count scanner with per-channel window check
module clk_freq_scan_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int DWELL_CYCLES  = 3947598,
  parameter int CNT_W         = 23
) (
  input  logic                 iCLK_50M,
  input  logic                 iRST_50M_N,
  clk_freq_scan_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_DWELL   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              capt_vld_q, capt_vld_d;
  logic [SEL_W-1:0]  capt_ch_q, capt_ch_d;
  logic [23:0]       capt_cnt_q, capt_cnt_d;
  logic [NUM_CH-1:0] ok_q, ok_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              done_q, done_d;
  logic              in_win;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wait_d     = wait_q;
    sel_d      = sel_q;
    capt_vld_d = 1'b0;
    capt_ch_d  = capt_ch_q;
    capt_cnt_d = capt_cnt_q;
    ok_d       = ok_q;
    done_d     = 1'b0;
    in_win     = (bus.iCLK_CNT >= bus.iCNT_MIN) && (bus.iCLK_CNT <= bus.iCNT_MAX);
    // Clear is applied first so a failure in the same cycle still sets its bit.
    err_d      = bus.iERR_CLR ? '0 : err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.iENABLE) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!bus.iENABLE) begin
          state_d = S_IDLE;
        end else begin
          sel_d   = ch_q;
          wait_d  = CNT_W'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!bus.iENABLE) begin
          state_d = S_IDLE;
        end else if (wait_q == '0) begin
          wait_d  = CNT_W'(DWELL_CYCLES - 1);
          state_d = S_DWELL;
        end else begin
          wait_d  = wait_q - CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (!bus.iENABLE) begin
          state_d = S_IDLE;
        end else if (wait_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d  = wait_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        // Results are registered here so they appear during NEXT.
        capt_vld_d  = 1'b1;
        capt_ch_d   = ch_q;
        capt_cnt_d  = bus.iCLK_CNT;
        ok_d[ch_q]  = in_win;
        if (!in_win) err_d[ch_q] = 1'b1;
        done_d      = (ch_q == LAST_CH);
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
        state_d = bus.iENABLE ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50M or negedge iRST_50M_N) begin
    if (!iRST_50M_N) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      wait_q     <= '0;
      sel_q      <= '0;
      capt_vld_q <= 1'b0;
      capt_ch_q  <= '0;
      capt_cnt_q <= '0;
      ok_q       <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      wait_q     <= wait_d;
      sel_q      <= sel_d;
      capt_vld_q <= capt_vld_d;
      capt_ch_q  <= capt_ch_d;
      capt_cnt_q <= capt_cnt_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign bus.oSEL       = sel_q;
  assign bus.oCAPT_VLD  = capt_vld_q;
  assign bus.oCAPT_CH   = capt_ch_q;
  assign bus.oCAPT_CNT  = capt_cnt_q;
  assign bus.oFREQ_OK   = ok_q;
  assign bus.oFREQ_ERR  = err_q;
  assign bus.oSCAN_DONE = done_q;

endmodule

// File: tb/tb_clk_freq_scan_ctrl.sv
// tb/tb_clk_freq_scan_ctrl.sv - scoreboard bench for clk_freq_scan_ctrl
module tb_clk_freq_scan_ctrl;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [23:0] GOOD = 24'h800000;

  typedef struct {
    int          ch;
    logic [23:0] cnt;
    logic [3:0]  ok;
    logic [3:0]  err;
    logic        done;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        sbq[$];
  exp_t        e;
  logic [3:0]  m_ok = '0;
  logic [3:0]  m_err = '0;
  logic [23:0] m_min, m_max;

  clk_freq_scan_ctrl_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  clk_freq_scan_ctrl #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .SETTLE_CYCLES(4), .DWELL_CYCLES(10), .CNT_W(23)
  ) dut (
    .iCLK_50M  (clk),
    .iRST_50M_N(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"},  32'(bus.oSEL), 0);
    check({tag, "_vld"},  32'(bus.oCAPT_VLD), 0);
    check({tag, "_ch"},   32'(bus.oCAPT_CH), 0);
    check({tag, "_cnt"},  32'(bus.oCAPT_CNT), 0);
    check({tag, "_ok"},   32'(bus.oFREQ_OK), 0);
    check({tag, "_err"},  32'(bus.oFREQ_ERR), 0);
    check({tag, "_done"}, 32'(bus.oSCAN_DONE), 0);
  endtask

  task automatic set_win(input logic [23:0] mn, input logic [23:0] mx);
    m_min = mn;
    m_max = mx;
    bus.iCNT_MIN = mn;
    bus.iCNT_MAX = mx;
  endtask

  // Called #1 after the edge that put the DUT into SELECT for this channel.
  task automatic do_ch(input int ch, input logic [23:0] cnt, input logic clr);
    logic fail;
    exp_t x;
    bus.iCLK_CNT = cnt;
    fail = !((cnt >= m_min) && (cnt <= m_max));
    if (clr) m_err = '0;
    m_ok[ch] = !fail;
    if (fail) m_err[ch] = 1'b1;
    x.ch = ch; x.cnt = cnt; x.ok = m_ok; x.err = m_err;
    x.done = (ch == NUM_CH - 1); x.cyc = cyc + 16;
    sbq.push_back(x);
    @(posedge clk); #1;
    check("sel", 32'(bus.oSEL), 32'(ch));
    repeat (14) @(posedge clk);
    #1 bus.iERR_CLR = clr;
    @(posedge clk); #1 bus.iERR_CLR = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.oCAPT_VLD) begin
        if (sbq.size() == 0) begin
          check("capt_vld_unexpected", 32'(bus.oCAPT_VLD), 0);
        end else begin
          e = sbq.pop_front();
          check("capt_cycle", 32'(cyc), 32'(e.cyc));
          check("capt_ch",    32'(bus.oCAPT_CH), 32'(e.ch));
          check("capt_cnt",   32'(bus.oCAPT_CNT), 32'(e.cnt));
          check("freq_ok",    32'(bus.oFREQ_OK), 32'(e.ok));
          check("freq_err",   32'(bus.oFREQ_ERR), 32'(e.err));
          check("scan_done",  32'(bus.oSCAN_DONE), 32'(e.done));
        end
      end else begin
        check("scan_done_orphan", 32'(bus.oSCAN_DONE), 0);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.iENABLE  = 1'b0;
    bus.iCLK_CNT = '0;
    bus.iERR_CLR = 1'b0;
    set_win(24'h7FF000, 24'h801000);
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1 check_zero("idle");

    bus.iENABLE = 1'b1;
    @(posedge clk); #1;
    // All-good scan, then wrap back to ch0
    for (int c = 0; c < NUM_CH; c++) do_ch(c, GOOD, 1'b0);
    // ch2 low by one count
    for (int c = 0; c < NUM_CH; c++) do_ch(c, (c == 2) ? 24'h7FEFFF : GOOD, 1'b0);
    for (int c = 0; c < NUM_CH; c++) do_ch(c, GOOD, 1'b0);
    // Window edges
    do_ch(0, 24'h7FF000, 1'b0);
    do_ch(1, 24'h801000, 1'b0);
    do_ch(2, 24'h801001, 1'b0);
    do_ch(3, GOOD, 1'b0);
    // Inverted window: everything fails
    set_win(24'h000010, 24'h00000F);
    for (int c = 0; c < NUM_CH; c++) do_ch(c, GOOD, 1'b0);
    set_win(24'h7FF000, 24'h801000);
    // Build ERR=4'h6, then clear coinciding with a ch0 failure
    do_ch(0, GOOD, 1'b1);
    do_ch(1, 24'h000001, 1'b0);
    do_ch(2, 24'hFFFFFF, 1'b0);
    do_ch(3, GOOD, 1'b0);
    do_ch(0, 24'h000000, 1'b1);

    // Drop enable mid-dwell of ch1
    repeat (8) @(posedge clk);
    #1 bus.iENABLE = 1'b0;
    repeat (30) @(posedge clk);
    #1 check("sel_hold_idle", 32'(bus.oSEL), 1);
    bus.iENABLE = 1'b1;
    @(posedge clk); #1;
    do_ch(1, GOOD, 1'b0);

    // Async reset mid-dwell of ch2
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    m_ok  = '0;
    m_err = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_ch(0, GOOD, 1'b0);
    bus.iENABLE = 1'b0;
    repeat (25) @(posedge clk);
    #1 check("sb_empty", 32'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clk_freq_scan_ctrl.md
Name: clk_freq_scan_ctrl

Overview:
- Time-multiplexes one clock-count sampler across NUM_CH candidate clocks (SERDES recovered clocks, reference clocks).
- Drives the clock-mux select and waits for the mux and sampler pipeline to settle. It discards contaminated measurement windows, then captures the synced 24-bit count.
- Checks each captured count against a min/max window and keeps live and sticky per-channel frequency status for software.
- Sits in the 50 MHz diagnostic domain beside the sampler and its clock mux.

Parameters:
- NUM_CH, 4, number of clocks scanned (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CH.
- SETTLE_CYCLES, 64, 50M cycles held after a select change before dwell starts (mux glitch/reset recovery).
- DWELL_CYCLES, 3947598, 50M cycles waited before capture: two full sampler windows plus 16 cycles of sync margin.
- CNT_W, 23, width of the internal wait counter; must hold max(SETTLE_CYCLES, DWELL_CYCLES).

Ports:
- iCLK_50M  in  1  50 MHz clock.
- iRST_50M_N  in  1  asynchronous active-low reset.
- iENABLE  in  1  level; 1 = scanning runs.
- iCNT_MIN  in  24  inclusive lower count limit, common to all channels; quasi-static.
- iCNT_MAX  in  24  inclusive upper count limit; quasi-static.
- iCLK_CNT  in  24  sampler count, already synchronised to iCLK_50M.
- iERR_CLR  in  1  one-cycle pulse; clears oFREQ_ERR.
- oSEL  out  SEL_W  clock-mux select.
- oCAPT_VLD  out  1  one-cycle pulse; a capture completed.
- oCAPT_CH  out  SEL_W  channel of the last capture.
- oCAPT_CNT  out  24  count of the last capture.
- oFREQ_OK  out  NUM_CH  per-channel result of the latest check.
- oFREQ_ERR  out  NUM_CH  sticky per-channel failure flags.
- oSCAN_DONE  out  1  one-cycle pulse after the last channel is captured.

Behaviour:
- Reset: all outputs 0; state IDLE; channel pointer ch = 0; wait counter 0.
- States: IDLE, SELECT, SETTLE, DWELL, CAPTURE, NEXT.
- IDLE: oSEL holds its last value. When iENABLE = 1, go to SELECT next cycle.
- SELECT (1 cycle): oSEL <= ch; wait counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement the wait counter. At 0, load DWELL_CYCLES-1 and go to DWELL. Total time in SETTLE = SETTLE_CYCLES cycles.
- DWELL: decrement. At 0, go to CAPTURE. Total time = DWELL_CYCLES cycles.
- CAPTURE (1 cycle): register iCLK_CNT. On the following cycle:
  - oCAPT_VLD = 1; oCAPT_CH = ch; oCAPT_CNT = captured value.
  - oFREQ_OK[ch] = (iCNT_MIN <= cnt <= iCNT_MAX), unsigned compare.
  - If the check fails, oFREQ_ERR[ch] is set.
- NEXT (1 cycle, coincides with oCAPT_VLD):
  - If ch == NUM_CH-1: ch <= 0 and oSCAN_DONE pulses this cycle.
  - Otherwise ch <= ch+1.
  - Go to SELECT if iENABLE = 1, else IDLE.
- Per-channel period: SETTLE_CYCLES + DWELL_CYCLES + 3 cycles, from SELECT entry to the next SELECT entry.
- oCAPT_CH/oCAPT_CNT hold between captures. oFREQ_OK bits of other channels are unchanged.
- iENABLE falling in SELECT/SETTLE/DWELL: go to IDLE next cycle. No capture, ch is not advanced, status is untouched.
- On re-enable, scanning resumes at the same ch with a full settle and dwell.
- iENABLE falling in CAPTURE: the capture completes; NEXT then goes to IDLE.
- iCNT_MIN > iCNT_MAX: every check fails (OK = 0, ERR set). No special case.
- Boundary counts equal to iCNT_MIN or iCNT_MAX pass.
- iERR_CLR in the same cycle a failure sets bit ch: bit ch ends at 1 (set wins); all other bits clear.
- Channels are never scanned past NUM_CH-1. oSEL never shows a value >= NUM_CH.
- Async reset mid-scan: immediate return to reset values. No partial capture pulse.

Test Plan:
- NUM_CH=4, SETTLE=4, DWELL=10; enable; iCLK_CNT=0x800000, MIN=0x7FF000, MAX=0x801000:
  - oSEL steps 0,1,2,3,0.
  - oCAPT_VLD every 17 cycles, first 16 cycles after SELECT entry.
  - oFREQ_OK=4'hF; oSCAN_DONE coincides with the ch3 capture; oFREQ_ERR=0.
- Same setup, iCLK_CNT=0x7FEFFF during ch2 capture only: oFREQ_OK=4'hB, oFREQ_ERR=4'h4. Next scan with a good count: oFREQ_OK=4'hF, oFREQ_ERR still 4'h4.
- Boundaries: count = 0x7FF000 and count = 0x801000 pass; 0x801001 fails. MIN=0x10, MAX=0x0F: all channels fail.
- Deassert iENABLE mid-DWELL of ch1: no oCAPT_VLD; state IDLE; oSEL stays 1. Re-enable: ch1 capture arrives a full 16 cycles after SELECT.
- Hold iERR_CLR=1 in the cycle ch0 fails, with ERR=4'h6 previously: result ERR=4'h1.
- Assert iRST_50M_N=0 during DWELL: all outputs 0 asynchronously. After release, scanning restarts at ch0.
